ldm_stm_sequencer: RTL
======================

# ldm_stm_sequencer

Multi-cycle sequencer for ARM block transfers (LDM/STM). It sits between decode and the register file. Decode hands it a register list, a base register and an addressing mode. It then walks the list one register per memory beat: it reads the register file ports for stores and the base value, and drives the register file write port for loads and the base writeback. While busy it owns the register file read/write ports and the memory request port.

## Interface
Parameters:
- WORD_SIZE, 32, datapath width
- NUM_REGS, 16, architectural registers / register-list width
- ADDR_WIDTH, 4, register index width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  begin transfer; sampled only in IDLE
- is_load  in  1  1 = LDM, 0 = STM
- pre_index  in  1  ARM P bit
- up  in  1  ARM U bit
- writeback  in  1  ARM W bit
- base_reg  in  ADDR_WIDTH  base register index
- reg_list  in  NUM_REGS  register list, bit i = ri
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle completion pulse
- read_rn  out  ADDR_WIDTH  register file read port A address (base)
- rn_in  in  WORD_SIZE  register file port A data, combinational
- read_rm  out  ADDR_WIDTH  register file read port B address (store data)
- rm_in  in  WORD_SIZE  register file port B data, combinational
- rd_we  out  1  register file write enable
- write_rd  out  ADDR_WIDTH  register file write address
- rd_out  out  WORD_SIZE  register file write data
- mem_req  out  1  memory request
- mem_we  out  1  1 = store beat
- mem_addr  out  WORD_SIZE  word address, byte units
- mem_wdata  out  WORD_SIZE  store data
- mem_rdata  in  WORD_SIZE  load data, valid when mem_ready is high
- mem_ready  in  1  beat accepted / completed this cycle

## Operation
- **States:** IDLE, XFER, WB, DONE.
- **IDLE:**
  - read_rn = base_reg at all times.
  - On start, latch is_load, the mode bits, base_reg, reg_list and base = rn_in.
  - Compute N = popcount(reg_list).
  - Set the first address: IA = base, IB = base+4, DA = base−4N+4, DB = base−4N. All arithmetic is modulo 2^WORD_SIZE.
  - Set final = up ? base+4N : base−4N.
  - Go to XFER, or to DONE if reg_list is 0. An empty list causes no beats and no writeback.
- **XFER:**
  - cur = lowest set bit of the remaining list. Registers always go lowest index to lowest address.
  - Drive mem_req=1, mem_addr=addr, mem_we=!is_load, read_rm=cur, mem_wdata=rm_in.
  - Outputs hold stable while mem_ready=0.
  - On mem_ready, for a load: rd_we=1, write_rd=cur, rd_out=mem_rdata in the same cycle.
  - On mem_ready: clear bit cur and set addr += 4.
  - If the list becomes empty: go to WB if writeback and not (is_load and base_reg in list), else go to DONE.
- **WB:** rd_we=1, write_rd=base_reg, rd_out=final. Go to DONE.
- **DONE:** done=1. Go to IDLE.
- **Base in list, STM:** the stored value is the original base. Writeback occurs only after all beats.
- **Base in list, LDM:** the loaded value wins and writeback is suppressed.
- start while not IDLE is ignored.
- **Idle outputs:** outside XFER, mem_req=0 and mem_we=0. rd_we=0 except as stated above.

## Timing
- **Reset values:** state IDLE; busy, done, rd_we, mem_req and mem_we = 0; all address and data outputs = 0, except read_rn, which follows base_reg.
- **Reset mid-operation:** abort the transfer. Outputs return to reset values on the next cycle. No further register writes or memory beats occur. The partially completed transfer is not undone.
- **Latency:** start in cycle 0 → first beat in cycle 1. With mem_ready held high, one beat per cycle. done arrives in cycle N+1, or N+2 with writeback. For an empty list, done arrives in cycle 1.
- **Register file writes** take effect at the clock edge ending the rd_we cycle.
- **Memory beats** complete only in cycles where mem_req and mem_ready are both high.

## Structure
- **Shared package:** WORD_SIZE, NUM_REGS, ADDR_WIDTH, the state encoding, and the P/U mode encoding. These are shared with register_file and decode.
- **Sub-module:** `lowest_set_bit` (NUM_REGS-bit priority encoder returning index plus a valid flag). It is reused for cur selection and the empty check.
- Popcount stays inline.

## Test plan
- **STMIA, writeback:** r0=0x100, list 0x000E, W=1, mem_ready=1 → stores r1, r2, r3 to 0x100, 0x104, 0x108 in cycles 1–3. WB in cycle 4 writes r0=0x10C. done in cycle 5.
- **LDMDB, writeback:** r13=0x200, list 0x00F0, W=1 → loads 0x1F0, 0x1F4, 0x1F8, 0x1FC into r4–r7 in order. r13 ends at 0x1F0.
- **LDMIA, base in list:** r2=0x40, list 0x0006, W=1 → r1=mem[0x40], r2=mem[0x44]. No WB cycle. done in cycle 3.
- **Memory stall:** STMIB with mem_ready low for 3 cycles on the second beat → mem_addr, mem_wdata and mem_req are held stable. The beat count is unchanged. done is delayed by exactly 3 cycles.
- **Empty list:** start with list 0 → no mem_req and no rd_we. done in cycle 1.
- **Reset mid-transfer:** reset asserted in cycle 2 of a 4-register LDM → cycle 3 shows busy=0, mem_req=0, rd_we=0. A following start runs a full transfer correctly.

Source files
------------

// File: rtl/ldm_stm_sequencer_pkg.sv
// ldm_stm_sequencer_pkg
//   Shared definitions for the LDM/STM sequencer, register file and decode:
//   datapath sizes, the sequencer state encoding and the ARM P/U addressing
//   mode encoding.
package ldm_stm_sequencer_pkg;

    localparam int WORD_SIZE  = 32;
    localparam int NUM_REGS   = 16;
    localparam int ADDR_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_WB   = 2'd2,
        ST_DONE = 2'd3
    } seq_state_e;

    // Encoded as {P, U}
    typedef enum logic [1:0] {
        MODE_DA = 2'b00,
        MODE_IA = 2'b01,
        MODE_DB = 2'b10,
        MODE_IB = 2'b11
    } pu_mode_e;

endpackage

// File: rtl/ldm_stm_sequencer_lowest_set_bit.sv
// lowest_set_bit
//   Priority encoder: returns the index of the lowest set bit of vec_i.
//   Ports:
//     vec_i   in  N   input vector
//     idx_o   out W   index of lowest set bit (0 when vec_i is zero)
//     valid_o out 1   vec_i has at least one bit set
import ldm_stm_sequencer_pkg::*;

module lowest_set_bit #(
    parameter int N = NUM_REGS,
    parameter int W = ADDR_WIDTH
) (
    input  logic [N-1:0] vec_i,
    output logic [W-1:0] idx_o,
    output logic         valid_o
);

    always_comb begin
        idx_o   = '0;
        valid_o = |vec_i;
        // Walk downward so the lowest set bit is the last one to win
        for (int i = N - 1; i >= 0; i--) begin
            if (vec_i[i]) idx_o = W'(i);
        end
    end

endmodule

// File: rtl/ldm_stm_sequencer.sv
// ldm_stm_sequencer
//   Multi-cycle sequencer for ARM LDM/STM block transfers. Takes a register
//   list, base register and P/U/W mode from decode and walks the list one
//   register per memory beat, lowest register at the lowest address, then
//   optionally writes the updated base back.
//   Ports:
//     clk, reset                     clock, synchronous active-high reset
//     start, is_load, pre_index, up,
//     writeback, base_reg, reg_list  transfer request from decode
//     busy, done                     status (done is a one-cycle pulse)
//     read_rn/rn_in                  register file port A (base)
//     read_rm/rm_in                  register file port B (store data)
//     rd_we, write_rd, rd_out        register file write port
//     mem_req, mem_we, mem_addr,
//     mem_wdata, mem_rdata, mem_ready memory beat interface
import ldm_stm_sequencer_pkg::*;

module ldm_stm_sequencer #(
    parameter int WORD_SIZE  = ldm_stm_sequencer_pkg::WORD_SIZE,
    parameter int NUM_REGS   = ldm_stm_sequencer_pkg::NUM_REGS,
    parameter int ADDR_WIDTH = ldm_stm_sequencer_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  is_load,
    input  logic                  pre_index,
    input  logic                  up,
    input  logic                  writeback,
    input  logic [ADDR_WIDTH-1:0] base_reg,
    input  logic [NUM_REGS-1:0]   reg_list,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] read_rn,
    input  logic [WORD_SIZE-1:0]  rn_in,
    output logic [ADDR_WIDTH-1:0] read_rm,
    input  logic [WORD_SIZE-1:0]  rm_in,
    output logic                  rd_we,
    output logic [ADDR_WIDTH-1:0] write_rd,
    output logic [WORD_SIZE-1:0]  rd_out,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [WORD_SIZE-1:0]  mem_addr,
    output logic [WORD_SIZE-1:0]  mem_wdata,
    input  logic [WORD_SIZE-1:0]  mem_rdata,
    input  logic                  mem_ready
);

    localparam logic [WORD_SIZE-1:0] FOUR = WORD_SIZE'(4);

    seq_state_e            state_q, state_d;
    logic                  is_load_q, is_load_d;
    logic                  wb_q, wb_d;
    logic [ADDR_WIDTH-1:0] base_reg_q, base_reg_d;
    logic [NUM_REGS-1:0]   list_q, list_d;
    logic [WORD_SIZE-1:0]  addr_q, addr_d;
    logic [WORD_SIZE-1:0]  final_q, final_d;

    logic [ADDR_WIDTH-1:0] cur;
    logic                  cur_vld;
    logic [NUM_REGS-1:0]   list_rest;
    logic [ADDR_WIDTH-1:0] rest_idx;
    logic                  rest_vld;
    int                    n_cnt;
    logic [WORD_SIZE-1:0]  four_n;
    pu_mode_e              mode;

    // Current register, and whether anything remains once it is retired
    lowest_set_bit #(.N(NUM_REGS), .W(ADDR_WIDTH)) u_cur (
        .vec_i   (list_q),
        .idx_o   (cur),
        .valid_o (cur_vld)
    );

    assign list_rest = list_q & ~(NUM_REGS'(1) << cur);

    lowest_set_bit #(.N(NUM_REGS), .W(ADDR_WIDTH)) u_rest (
        .vec_i   (list_rest),
        .idx_o   (rest_idx),
        .valid_o (rest_vld)
    );

    always_comb begin
        n_cnt = 0;
        for (int i = 0; i < NUM_REGS; i++) begin
            n_cnt = n_cnt + int'(reg_list[i]);
        end
        four_n = WORD_SIZE'(n_cnt) << 2;
    end

    assign mode    = pu_mode_e'({pre_index, up});
    assign read_rn = base_reg;
    assign busy    = (state_q != ST_IDLE);

    always_comb begin
        state_d    = state_q;
        is_load_d  = is_load_q;
        wb_d       = wb_q;
        base_reg_d = base_reg_q;
        list_d     = list_q;
        addr_d     = addr_q;
        final_d    = final_q;

        done      = 1'b0;
        read_rm   = '0;
        rd_we     = 1'b0;
        write_rd  = '0;
        rd_out    = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    is_load_d  = is_load;
                    base_reg_d = base_reg;
                    list_d     = reg_list;
                    // A load that overwrites the base keeps the loaded value
                    wb_d       = writeback & ~(is_load & reg_list[base_reg]);
                    final_d    = up ? (rn_in + four_n) : (rn_in - four_n);
                    unique case (mode)
                        MODE_IA: addr_d = rn_in;
                        MODE_IB: addr_d = rn_in + FOUR;
                        MODE_DA: addr_d = rn_in - four_n + FOUR;
                        MODE_DB: addr_d = rn_in - four_n;
                        default: addr_d = rn_in;
                    endcase
                    state_d = (|reg_list) ? ST_XFER : ST_DONE;
                end
            end
            ST_XFER: begin
                mem_req   = 1'b1;
                mem_we    = ~is_load_q;
                mem_addr  = addr_q;
                read_rm   = cur;
                mem_wdata = rm_in;
                if (mem_ready && cur_vld) begin
                    if (is_load_q) begin
                        rd_we    = 1'b1;
                        write_rd = cur;
                        rd_out   = mem_rdata;
                    end
                    list_d = list_rest;
                    addr_d = addr_q + FOUR;
                    if (!rest_vld) state_d = wb_q ? ST_WB : ST_DONE;
                end
            end
            ST_WB: begin
                rd_we    = 1'b1;
                write_rd = base_reg_q;
                rd_out   = final_q;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            is_load_q  <= 1'b0;
            wb_q       <= 1'b0;
            base_reg_q <= '0;
            list_q     <= '0;
            addr_q     <= '0;
            final_q    <= '0;
        end else begin
            state_q    <= state_d;
            is_load_q  <= is_load_d;
            wb_q       <= wb_d;
            base_reg_q <= base_reg_d;
            list_q     <= list_d;
            addr_q     <= addr_d;
            final_q    <= final_d;
        end
    end

    // rest_idx is only needed for its valid flag
    logic unused_ok;
    assign unused_ok = ^rest_idx;

endmodule
